// File: rtl/fifo_pkg.sv
// Purpose: shared pointer helpers for the async FIFO read and write pointer controllers.
// Latency: combinational functions only; no state.
// Backpressure: not applicable; the pointer controllers own flow control.
package fifo_pkg;

  // Widest pointer these helpers handle; callers zero-extend into it and slice the result.
  localparam int unsigned GRAY_MAX_W = 32;

  // Pointers carry one extra MSB over the RAM address to tell laps apart.
  function automatic int unsigned ptr_width(input int unsigned adr_w);
    return adr_w + 1;
  endfunction

  // Width-agnostic: a zero-extended binary value maps to a zero-extended Gray value.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB; zero upper bits leave the low slice exact for any width.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Purpose: N-stage flop synchroniser for a Gray-coded pointer crossing clock domains.
// Latency: N destination-clock edges from input change to output.
// Backpressure: none; it samples every edge and never stalls.
module gray_sync #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (N < 2) begin : g_bad_stages
    $error("gray_sync: N must be at least 2");
  end

  logic [W-1:0] stage_q [N];

  // Plain shift chain with nothing between stages so only one Gray bit can be in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < int'(N); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[N-1];

endmodule

// File: rtl/read_ptr_empty.sv
// Purpose: read-side pointer, empty/almost-empty/level flags and sticky underflow of the async FIFO.
// Latency: read accepted same edge; a write shows up sync_stages+1 read_clk edges later.
// Backpressure: reads while FIFO_empty are refused (pointer holds) and latch underflow.
module read_ptr_empty
  import fifo_pkg::*;
#(
  parameter int unsigned depth            = 8,
  parameter int unsigned adr_width        = $clog2(depth),
  parameter int unsigned sync_stages      = 2,
  parameter int unsigned almost_empty_thr = 2
) (
  input  logic                 read_clk,
  input  logic                 rst_n,
  input  logic                 read_en,
  input  logic [adr_width:0]   write_ptr_gray,
  input  logic                 clear_underflow,
  output logic [adr_width-1:0] read_adr,
  output logic [adr_width:0]   read_ptr_gray,
  output logic                 FIFO_empty,
  output logic                 FIFO_almost_empty,
  output logic [adr_width:0]   read_level,
  output logic                 underflow
);

  localparam int unsigned PW = ptr_width(adr_width);
  localparam logic [PW-1:0] AE_THR = PW'(almost_empty_thr);

  if (depth < 4 || (depth & (depth - 1)) != 0) begin : g_bad_depth
    $error("read_ptr_empty: depth must be a power of two and at least 4");
  end
  if (adr_width != $clog2(depth)) begin : g_bad_adr
    $error("read_ptr_empty: adr_width must equal clog2(depth)");
  end
  if (sync_stages < 2) begin : g_bad_sync
    $error("read_ptr_empty: sync_stages must be at least 2");
  end
  if (almost_empty_thr > depth - 1) begin : g_bad_thr
    $error("read_ptr_empty: almost_empty_thr must be in 0..depth-1");
  end

  logic [PW-1:0]         rbin_q, rbin_d;
  logic [PW-1:0]         rgray_q, rgray_d;
  logic [PW-1:0]         level_q, level_d;
  logic [PW-1:0]         wsync, wbin;
  logic                  empty_q, empty_d;
  logic                  aempty_q, aempty_d;
  logic                  uf_q, uf_d;
  logic                  rd_ok;
  logic [GRAY_MAX_W-1:0] rgray_full, wbin_full;
  logic                  unused_hi;

  gray_sync #(
    .N (sync_stages),
    .W (PW)
  ) u_wsync (
    .clk   (read_clk),
    .rst_n (rst_n),
    .d_i   (write_ptr_gray),
    .q_o   (wsync)
  );

  // Flags are derived from the next pointer so the read that drains the FIFO raises empty on its own edge.
  always_comb begin
    rd_ok      = read_en & ~empty_q;
    rbin_d     = rd_ok ? rbin_q + PW'(1) : rbin_q;
    rgray_full = bin2gray(GRAY_MAX_W'(rbin_d));
    rgray_d    = rgray_full[PW-1:0];
    wbin_full  = gray2bin(GRAY_MAX_W'(wsync));
    wbin       = wbin_full[PW-1:0];
    level_d    = wbin - rbin_d;
    empty_d    = (rgray_d == wsync);
    aempty_d   = (level_d <= AE_THR);
    uf_d       = (read_en & empty_q) | (uf_q & ~clear_underflow);
  end

  assign unused_hi = ^{rgray_full[GRAY_MAX_W-1:PW], wbin_full[GRAY_MAX_W-1:PW]};

  // All read-domain state; reset drops everything at once and reports an empty FIFO.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q   <= '0;
      rgray_q  <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      uf_q     <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      uf_q     <= uf_d;
    end
  end

  assign read_adr          = rbin_q[adr_width-1:0];
  assign read_ptr_gray     = rgray_q;
  assign read_level        = level_q;
  assign FIFO_empty        = empty_q;
  assign FIFO_almost_empty = aempty_q;
  assign underflow         = uf_q;

endmodule

// File: tb/tb_read_ptr_empty.sv
// Purpose: self-checking bench for read_ptr_empty against a count-based occupancy model.
// Latency: model delays the write count by the synchroniser depth before it affects flags.
// Backpressure: stimulus never lets writes run more than depth ahead of accepted reads.
module tb_read_ptr_empty;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int PW    = 4;
  localparam int SYNC  = 2;
  localparam int THR   = 2;

  logic          read_clk = 1'b0;
  logic          rst_n;
  logic          read_en;
  logic          clear_underflow;
  logic [PW-1:0] write_ptr_gray;
  logic [AW-1:0] read_adr, z_read_adr;
  logic [PW-1:0] read_ptr_gray, z_read_ptr_gray;
  logic [PW-1:0] read_level, z_read_level;
  logic          FIFO_empty, z_FIFO_empty;
  logic          FIFO_almost_empty, z_FIFO_almost_empty;
  logic          underflow, z_underflow;

  int checks   = 0;
  int failures = 0;
  bit auto_on  = 1'b0;

  // Model state: counts of words written/read since reset, unbounded integers.
  int wc = 0;
  int rc = 0;
  int hist[$];
  bit m_empty = 1'b1;
  bit m_ae    = 1'b1;
  bit m_ae0   = 1'b1;
  bit m_uf    = 1'b0;
  int m_level = 0;

  always #5 read_clk = ~read_clk;

  function automatic int gray(input int v);
    return v ^ (v >> 1);
  endfunction

  always_comb write_ptr_gray = PW'(gray(wc % (2 * DEPTH)));

  read_ptr_empty #(
    .depth(DEPTH), .adr_width(AW), .sync_stages(SYNC), .almost_empty_thr(THR)
  ) dut (
    .read_clk(read_clk), .rst_n(rst_n), .read_en(read_en),
    .write_ptr_gray(write_ptr_gray), .clear_underflow(clear_underflow),
    .read_adr(read_adr), .read_ptr_gray(read_ptr_gray), .FIFO_empty(FIFO_empty),
    .FIFO_almost_empty(FIFO_almost_empty), .read_level(read_level), .underflow(underflow)
  );

  read_ptr_empty #(
    .depth(DEPTH), .adr_width(AW), .sync_stages(SYNC), .almost_empty_thr(0)
  ) dut0 (
    .read_clk(read_clk), .rst_n(rst_n), .read_en(read_en),
    .write_ptr_gray(write_ptr_gray), .clear_underflow(clear_underflow),
    .read_adr(z_read_adr), .read_ptr_gray(z_read_ptr_gray), .FIFO_empty(z_FIFO_empty),
    .FIFO_almost_empty(z_FIFO_almost_empty), .read_level(z_read_level), .underflow(z_underflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge read_clk);
    #1;
  endtask

  // Reference: occupancy = (write count seen SYNC edges late) - (accepted reads).
  always @(posedge read_clk or negedge rst_n) begin : model
    bit rd_ok;
    if (!rst_n) begin
      rc = 0;
      hist = {};
      for (int i = 0; i < SYNC; i++) hist.push_back(0);
      m_empty = 1'b1; m_ae = 1'b1; m_ae0 = 1'b1; m_uf = 1'b0; m_level = 0;
    end else begin
      rd_ok = read_en && !m_empty;
      m_uf  = (read_en && m_empty) || (m_uf && !clear_underflow);
      if (rd_ok) rc++;
      hist.push_back(wc);
      while (hist.size() > SYNC + 1) void'(hist.pop_front());
      m_level = hist[0] - rc;
      m_empty = (m_level == 0);
      m_ae    = (m_level <= THR);
      m_ae0   = (m_level <= 0);
    end
  end

  // Scoreboard compare on the falling edge, away from the active edge.
  always @(negedge read_clk) begin
    if (auto_on) begin
      chk("sb_adr",   32'(read_adr),          32'(rc % DEPTH));
      chk("sb_gray",  32'(read_ptr_gray),     32'(gray(rc % (2 * DEPTH))));
      chk("sb_level", 32'(read_level),        32'(m_level));
      chk("sb_empty", 32'(FIFO_empty),        32'(m_empty));
      chk("sb_aempt", 32'(FIFO_almost_empty), 32'(m_ae));
      chk("sb_uf",    32'(underflow),         32'(m_uf));
      chk("sb_ae0",   32'(z_FIFO_almost_empty), 32'(m_ae0));
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_adr"},   32'(read_adr),          32'(0));
    chk({tag, "_gray"},  32'(read_ptr_gray),     32'(0));
    chk({tag, "_empty"}, 32'(FIFO_empty),        32'(1));
    chk({tag, "_aempt"}, 32'(FIFO_almost_empty), 32'(1));
    chk({tag, "_level"}, 32'(read_level),        32'(0));
    chk({tag, "_uf"},    32'(underflow),         32'(0));
  endtask

  initial begin
    int rd_pct;
    rst_n = 1'b0; read_en = 1'b0; clear_underflow = 1'b0; wc = 0;
    #12;
    chk_reset_vals("in_reset");
    step();
    rst_n   = 1'b1;
    auto_on = 1'b1;
    step();
    chk_reset_vals("idle");

    // Underflow: set beats a simultaneous clear, clear alone then drops it.
    read_en = 1'b1; clear_underflow = 1'b1;
    step();
    chk("uf_set_wins", 32'(underflow), 32'(1));
    chk("uf_adr_hold", 32'(read_adr),  32'(0));
    read_en = 1'b0;
    step();
    chk("uf_clear", 32'(underflow), 32'(0));
    clear_underflow = 1'b0;

    // Write pointer 1,2,3: empty falls on the third edge after the first write.
    wc = 1; step();
    chk("wr_empty_e1", 32'(FIFO_empty), 32'(1));
    wc = 2; step();
    chk("wr_empty_e2", 32'(FIFO_empty), 32'(1));
    wc = 3; step();
    chk("wr_empty_e3", 32'(FIFO_empty), 32'(0));
    chk("wr_level_e3", 32'(read_level), 32'(1));
    step();
    step();
    chk("wr_level3", 32'(read_level),        32'(3));
    chk("wr_aempt3", 32'(FIFO_almost_empty), 32'(0));

    // Drain three words.
    read_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("drain_adr", 32'(read_adr), 32'(i));
      step();
      chk("drain_level", 32'(read_level),        32'(2 - i));
      chk("drain_aempt", 32'(FIFO_almost_empty), 32'(1));
    end
    chk("drain_empty", 32'(FIFO_empty), 32'(1));
    read_en = 1'b0;

    // Level 5, then asynchronous reset mid-burst between clock edges.
    wc = 8;
    step(); step(); step();
    chk("pre_rst_level", 32'(read_level), 32'(5));
    read_en = 1'b1;
    #2;
    rst_n = 1'b0; wc = 0;
    #1;
    chk_reset_vals("async_rst");
    read_en = 1'b0;
    step();
    rst_n = 1'b1;

    // Full lap: eight words, pointer reaches 8.
    wc = 8;
    step(); step(); step();
    chk("lap1_level", 32'(read_level), 32'(8));
    chk("lap1_empty", 32'(FIFO_empty), 32'(0));
    read_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("lap1_adr", 32'(read_adr), 32'(i));
      step();
    end
    read_en = 1'b0;
    chk("lap1_gray",  32'(read_ptr_gray), 32'(4'b1100));
    chk("lap1_empty_end", 32'(FIFO_empty), 32'(1));
    chk("lap1_adr_end", 32'(read_adr), 32'(0));

    // Second lap: pointer wraps 15 -> 0.
    wc = 16;
    step(); step(); step();
    chk("lap2_level", 32'(read_level), 32'(8));
    read_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("lap2_adr", 32'(read_adr), 32'(i));
      step();
    end
    read_en = 1'b0;
    chk("wrap_gray",  32'(read_ptr_gray), 32'(0));
    chk("wrap_empty", 32'(FIFO_empty),    32'(1));
    chk("wrap_level", 32'(read_level),    32'(0));

    // Random traffic, read pressure varying by phase to visit both empty and full.
    rd_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) rd_pct = (n / 200 % 3 == 0) ? 20 : ((n / 200 % 3 == 1) ? 80 : 50);
      read_en         = ($urandom_range(0, 99) < rd_pct);
      clear_underflow = ($urandom_range(0, 9) == 0);
      if ((wc - rc) < DEPTH && $urandom_range(0, 1) == 1) wc++;
      step();
    end
    read_en = 1'b0; clear_underflow = 1'b0;
    step();
    auto_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
